// File: rtl/alu64_seq_ctrl.sv
// alu64_seq_ctrl: command sequencer around a 64-bit ALU datapath.
// One command is accepted at a time through start/busy/done. Single-pass ops
// (AND/OR/NOR/ADD/SUB/SLT) take one ALU pass. MUL is a shift-and-add loop that
// reuses the ALU adder for WIDTH cycles.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start, cmd      : command request (sampled only when not busy) and opcode
//   opa, opb        : operands, latched when start is accepted
//   busy, done      : busy in EXEC/MUL, done is a one-cycle completion pulse
//   result          : registered result, held until the next completion
//   overflow, zero  : registered flags (overflow only for ADD/SUB)
module alu64_seq_ctrl #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  localparam logic [2:0] CmdAnd = 3'b000;
  localparam logic [2:0] CmdOr  = 3'b001;
  localparam logic [2:0] CmdAdd = 3'b010;
  localparam logic [2:0] CmdSub = 3'b011;
  localparam logic [2:0] CmdNor = 3'b100;
  localparam logic [2:0] CmdSlt = 3'b101;
  localparam logic [2:0] CmdMul = 3'b110;
  localparam logic [2:0] CmdRsv = 3'b111;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_t;

  state_t           state_q;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] opa_q;   // doubles as the multiplicand during MUL
  logic [WIDTH-1:0] opb_q;   // doubles as the multiplier during MUL
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // ALU control lines and operands
  logic             ainvert, binvert, cin;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;

  always_comb begin
    ainvert = 1'b0;
    binvert = 1'b0;
    cin     = 1'b0;
    alu_op  = 2'b10;
    alu_a   = opa_q;
    alu_b   = opb_q;
    if (state_q == StMul) begin
      // Adder-only mode: acc + shifted multiplicand
      alu_a = acc_q;
      alu_b = opa_q;
    end else begin
      unique case (cmd_q)
        CmdAnd: alu_op = 2'b00;
        CmdOr:  alu_op = 2'b01;
        CmdNor: begin ainvert = 1'b1; binvert = 1'b1; alu_op = 2'b00; end
        CmdSub: begin binvert = 1'b1; cin = 1'b1; end
        CmdSlt: begin binvert = 1'b1; cin = 1'b1; alu_op = 2'b11; end
        default: alu_op = 2'b10;
      endcase
    end
  end

  // ALU datapath
  logic [WIDTH-1:0] a_eff, b_eff, alu_sum, alu_y, acc_next;
  logic             alu_ovf, alu_set;

  always_comb begin
    a_eff   = ainvert ? ~alu_a : alu_a;
    b_eff   = binvert ? ~alu_b : alu_b;
    alu_sum = a_eff + b_eff + {{(WIDTH-1){1'b0}}, cin};
    alu_ovf = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (alu_sum[WIDTH-1] != a_eff[WIDTH-1]);
    // Signed less-than: sign of a-b corrected by overflow
    alu_set = alu_sum[WIDTH-1] ^ alu_ovf;
    unique case (alu_op)
      2'b00:   alu_y = a_eff & b_eff;
      2'b01:   alu_y = a_eff | b_eff;
      2'b10:   alu_y = alu_sum;
      default: alu_y = {{(WIDTH-1){1'b0}}, alu_set};
    endcase
    acc_next = opb_q[0] ? alu_y : acc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cmd_q    <= 3'b000;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            cmd_q   <= cmd;
            opa_q   <= opa;
            opb_q   <= opb;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= (cmd == CmdMul) ? StMul : StExec;
          end else begin
            state_q <= StIdle;
          end
        end
        StExec: begin
          if (cmd_q == CmdRsv) begin
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b1;
          end else begin
            result   <= alu_y;
            overflow <= ((cmd_q == CmdAdd) || (cmd_q == CmdSub)) && alu_ovf;
            zero     <= (alu_y == '0);
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StMul: begin
          acc_q <= acc_next;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            result   <= acc_next;
            overflow <= 1'b0;
            zero     <= (acc_next == '0);
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu64_seq_ctrl.sv
// Bench for alu64_seq_ctrl: directed commands, expected results queued on issue
// and compared when done pulses.
module tb_alu64_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  cmd;
  logic [63:0] opa, opb;
  logic        busy, done, overflow, zero;
  logic [63:0] result;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int failed = 0;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    logic        zro;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];

  alu64_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cmd      (cmd),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] r;
    logic ov;
    ov = 1'b0;
    case (c)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin r = a + b; ov = (a[63] == b[63]) && (r[63] != a[63]); end
      3'b011: begin r = a - b; ov = (a[63] != b[63]) && (r[63] != a[63]); end
      3'b100: r = ~(a | b);
      3'b101: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'b110: r = a * b;
      default: r = 64'd0;
    endcase
    e.res = r;
    e.ovf = ov;
    e.zro = (r == 64'd0);
    e.lat = (c == 3'b110) ? 65 : 2;
    e.t0  = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic issue(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e = model(c, a, b);
    e.t0 = cyc;
    sb.push_back(e);
    start = 1'b1;
    cmd   = c;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    cmd   = 3'b000;
    opa   = 64'hDEAD_BEEF_0BAD_F00D;
    opb   = 64'h1234_5678_9ABC_DEF0;
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(input string tag);
    int n;
    bit seen;
    exp_t e;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    if (seen) begin
      if (sb.size() == 0) begin
        total++;
        failed++;
        $error("FAIL %s_unexpected observed=done expected=no_done", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, "_lat"},  64'(cyc - e.t0), 64'(e.lat));
        chk({tag, "_res"},  result, e.res);
        chk({tag, "_ovf"},  64'(overflow), 64'(e.ovf));
        chk({tag, "_zero"}, 64'(zero), 64'(e.zro));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmd   = 3'b000;
    opa   = 64'd0;
    opb   = 64'd0;
    #13;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res",  result, 64'd0);
    chk("rst_ovf",  64'(overflow), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD with latency and busy shape
    @(negedge clk);
    chk("add_busy_pre", 64'(busy), 64'd0);
    issue(3'b010, 64'd5, 64'd7);
    chk("add_busy_t1", 64'(busy), 64'd1);
    wait_done("add");
    @(negedge clk);
    chk("add_done_pulse", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("add_hold", result, 64'd12);

    @(negedge clk); issue(3'b011, 64'd3, 64'd3);                  wait_done("sub_eq");
    @(negedge clk); issue(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); wait_done("add_ovf");
    @(negedge clk); issue(3'b011, 64'h8000_0000_0000_0000, 64'd1); wait_done("sub_ovf");
    @(negedge clk); issue(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); wait_done("slt_neg");
    @(negedge clk); issue(3'b101, 64'd9, 64'hFFFF_FFFF_FFFF_FFF0); wait_done("slt_pos");
    @(negedge clk); issue(3'b100, 64'd0, 64'd0);                  wait_done("nor");
    @(negedge clk); issue(3'b001, 64'hF0F0_0000_1234_0000, 64'h0F0F_0000_0000_5678);
    wait_done("or");
    @(negedge clk); issue(3'b111, 64'h55, 64'hAA);                wait_done("rsv");
    @(negedge clk); issue(3'b110, 64'd6, 64'd7);                  wait_done("mul_6x7");
    @(negedge clk); issue(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2); wait_done("mul_wrap");

    // start during MUL cycle 10 must be ignored
    @(negedge clk);
    issue(3'b110, 64'd5, 64'd9);
    repeat (10) @(negedge clk);
    start = 1'b1; cmd = 3'b010; opa = 64'd1; opb = 64'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("mul_ign");
    repeat (3) @(negedge clk);
    chk("ign_no_done", 64'(done), 64'd0);
    chk("ign_no_busy", 64'(busy), 64'd0);
    chk("ign_hold", result, 64'd45);

    // Back-to-back: issue in the DONE cycle
    @(negedge clk);
    issue(3'b000, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0);
    wait_done("and");
    issue(3'b010, 64'd1, 64'd1);
    wait_done("b2b");

    // Asynchronous reset in MUL cycle 30
    @(negedge clk);
    issue(3'b110, 64'd123, 64'd456);
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_res",  result, 64'd0);
    chk("arst_ovf",  64'(overflow), 64'd0);
    chk("arst_zero", 64'(zero), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(3'b110, 64'd3, 64'd4);
    wait_done("mul_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
